bcd_ascii_sequencer: RTL and testbench
======================================

Name: bcd_ascii_sequencer

Overview:
- Accepts a packed multi-digit BCD word on a one-cycle start pulse and emits one 8-bit ASCII character per digit, most-significant digit first.
- Output is a valid/ready byte stream and feeds the UART/display text path.
- Digit-to-ASCII conversion is internal and matches the team's BCD-to-ASCII converter:
  - digits 0-9 map to {4'h3, digit}, i.e. 0x30-0x39;
  - non-BCD codes map to '?' (0x3F) and set an error flag.

Parameters:
- NDIGITS, 4, number of BCD digits per word (1..8).
- CNT_W, 3, width of the digit index counter; must satisfy 2^CNT_W >= NDIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; captures bcd_in when idle.
- bcd_in  input  4*NDIGITS  packed BCD; digit NDIGITS-1 in the top nibble, emitted first.
- busy  output  1  high from the cycle after an accepted start until done.
- ascii_out  output  8  current character; stable while ascii_valid=1 and ascii_ready=0.
- ascii_valid  output  1  character available.
- ascii_ready  input  1  downstream accepts ascii_out on a rising edge when ascii_valid=1.
- done  output  1  one-cycle pulse after the last character is accepted.
- err  output  1  sticky; set if any digit of the current word is >9; cleared on the next accepted start.

Behaviour:
- Reset: rst=1 sampled on a rising edge puts all outputs at 0 (busy, ascii_out=8'h00, ascii_valid, done, err), the state at IDLE, and clears the shift register and counter. Reset mid-word discards the pending character without handshake.
- States:
  - IDLE -> EMIT: on start=1. Register bcd_in into the shift register, set idx=NDIGITS-1, clear err.
  - EMIT: ascii_valid=1 and ascii_out=conv(top nibble).
    - If ascii_ready=1 and idx>0: shift left 4 bits, idx-1, stay in EMIT.
    - If ascii_ready=1 and idx=0: go to DONE.
    - If ascii_ready=0: hold all state.
  - DONE: done=1 for exactly one cycle, busy=0 and ascii_valid=0 in that cycle, then IDLE.
- Registered outputs: start in cycle N gives busy=1 and ascii_valid=1 in cycle N+1.
- Throughput: with ascii_ready tied high, one character per cycle. A word takes NDIGITS cycles in EMIT plus 1 cycle in DONE.
- Start while not IDLE (including DONE) is ignored; no queueing. Back-to-back words are possible: start asserted in the cycle after the DONE cycle is accepted.
- err: set in the cycle the offending digit is presented on ascii_out and held until the next accepted start; not cleared by done.
- ascii_valid never deasserts before acceptance. ascii_out changes only after an accepted handshake.
- The counter never wraps. idx=0 is the terminal condition; no underflow path.

Optional Feature:
- Macro: BCD_SEQ_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading 0x0 digits are skipped entirely, with no character and no cycle spent.
  - Blanking is evaluated as a combinational skip in IDLE->EMIT and in EMIT shifts while no nonzero digit has yet been emitted. The first emitted character appears in cycle N+1 regardless.
  - The final digit (idx=0) is always emitted, so all-zero input yields a single '0' (0x30).
  - An invalid digit (>9) counts as nonzero and ends blanking.
- Not defined: every digit is emitted, including leading zeros.

Test Plan:
- Basic word: NDIGITS=4, bcd_in=16'h1234, start pulse, ascii_ready=1 -> characters 0x31,0x32,0x33,0x34 on consecutive cycles starting one cycle after start; done pulses in the following cycle; err=0.
- Backpressure: bcd_in=16'h0907, ascii_ready toggled 0,0,1,0,1,1,1 -> ascii_out holds 0x30 through both stalled cycles; sequence 0x30,0x39,0x30,0x37 with no drop or duplicate.
- Invalid digit: bcd_in=16'h12A4 -> characters 0x31,0x32,0x3F,0x34; err rises with the 0x3F character and stays 1 after done; the next start with 16'h0000 clears err.
- Start while busy: second start with 16'h5555 during the emission of 16'h1234 -> ignored, only the 1234 characters appear; a start in the cycle after done is accepted.
- Reset mid-word: rst=1 while the second character is pending -> the next cycle shows ascii_valid=0, busy=0, done=0, ascii_out=0x00; no further characters.
- With BCD_SEQ_LEADING_ZERO_BLANK_EN: 16'h0042 -> 0x34,0x32 only; 16'h0000 -> a single 0x30; done follows the last character.

Source files
------------

// File: rtl/bcd_ascii_sequencer.sv
// Packed BCD word to MSD-first ASCII byte stream with valid/ready handshake.
// Optional leading-zero blanking: define BCD_SEQ_LEADING_ZERO_BLANK_EN.
module bcd_ascii_sequencer #(
  parameter int NDIGITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic [7:0]             ascii_out,
  output logic                   ascii_valid,
  input  logic                   ascii_ready,
  output logic                   done,
  output logic                   err
);

  localparam int W = 4 * NDIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [W-1:0]       sr_q;
  logic [CNT_W-1:0]   idx_q;
  logic [7:0]         ascii_out_q;
  logic               ascii_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [W-1:0]       load_d;
  logic [CNT_W-1:0]   load_idx_d;
  logic [W-1:0]       shift_d;
  logic [3:0]         load_top;
  logic [3:0]         shift_top;

  function automatic logic [7:0] conv(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  function automatic logic is_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
  int unsigned lz;
  logic        run;

  // All leading zeros are stripped at load time, so the first character
  // emitted is already nonzero (or the final digit) and EMIT needs no skip.
  always_comb begin
    lz  = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < NDIGITS - 1; i++) begin
      if (run && (bcd_in[W-1-4*i -: 4] == 4'h0)) begin
        lz = lz + 1;
      end else begin
        run = 1'b0;
      end
    end
    load_d     = bcd_in << (4 * lz);
    load_idx_d = CNT_W'(NDIGITS - 1 - lz);
  end
`else
  always_comb begin
    load_d     = bcd_in;
    load_idx_d = CNT_W'(NDIGITS - 1);
  end
`endif

  always_comb begin
    shift_d   = sr_q << 4;
    load_top  = load_d[W-1 -: 4];
    shift_top = shift_d[W-1 -: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sr_q          <= '0;
      idx_q         <= '0;
      ascii_out_q   <= '0;
      ascii_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q          <= load_d;
            idx_q         <= load_idx_d;
            ascii_out_q   <= conv(load_top);
            err_q         <= is_bad(load_top);
            ascii_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (ascii_ready) begin
            if (idx_q != '0) begin
              sr_q        <= shift_d;
              idx_q       <= idx_q - 1'b1;
              ascii_out_q <= conv(shift_top);
              err_q       <= err_q | is_bad(shift_top);
            end else begin
              ascii_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign ascii_out   = ascii_out_q;
  assign ascii_valid = ascii_valid_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bcd_ascii_sequencer.sv
// Directed self-checking bench for bcd_ascii_sequencer (NDIGITS=4).
module tb_bcd_ascii_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic [7:0]  ascii_out;
  logic        ascii_valid;
  logic        ascii_ready;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_ascii_sequencer #(.NDIGITS(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bcd_in      (bcd_in),
    .busy        (busy),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .done        (done),
    .err         (err)
  );

  // {busy, valid, done, err, ascii_out}
  function automatic logic [11:0] obs();
    return {busy, ascii_valid, done, err, ascii_out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    rst = 1'b1; start = 1'b0; bcd_in = '0; ascii_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    o = obs();
    n_total++;
    if (o !== 12'h000) $display("FAIL reset_state: got %h want %h", o, 12'h000);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o !== 12'h000) $display("FAIL reset_idle: got %h want %h", o, 12'h000);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [11:0] o;
    logic [31:0] e;
    e = 32'h31323334;
    ascii_ready = 1'b1; bcd_in = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = obs();
      n_total++;
      if (o !== {4'b1100, e[31-8*k -: 8]})
        $display("FAIL basic_char%0d: got %h want %h", k, o, {4'b1100, e[31-8*k -: 8]});
      else n_pass++;
      step();
    end
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL basic_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0000) $display("FAIL basic_after_done: got %b want %b", o[11:8], 4'b0000);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [11:0] o;
    logic [55:0] e;
    logic [6:0]  r;
    e = 56'h30303039393037;
    r = 7'b0010111;
    bcd_in = 16'h0907; start = 1'b1; ascii_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ascii_ready = r[6-k];
      o = obs();
      n_total++;
      if (o !== {4'b1100, e[55-8*k -: 8]})
        $display("FAIL bp_cycle%0d: got %h want %h", k, o, {4'b1100, e[55-8*k -: 8]});
      else n_pass++;
      step();
    end
    ascii_ready = 1'b1;
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL bp_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
  endtask

  task automatic test_invalid();
    logic [11:0] o;
    logic [31:0] e;
    logic [3:0]  eb;
    e  = 32'h31323F34;
    eb = 4'b0011;
    ascii_ready = 1'b1; bcd_in = 16'h12A4; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = obs();
      n_total++;
      if (o !== {3'b110, eb[3-k], e[31-8*k -: 8]})
        $display("FAIL inv_char%0d: got %h want %h", k, o, {3'b110, eb[3-k], e[31-8*k -: 8]});
      else n_pass++;
      step();
    end
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0011) $display("FAIL inv_done_err: got %b want %b", o[11:8], 4'b0011);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0001) $display("FAIL inv_err_sticky: got %b want %b", o[11:8], 4'b0001);
    else n_pass++;
    bcd_in = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = obs();
      n_total++;
      if (o !== 12'hC30) $display("FAIL inv_clear_char%0d: got %h want %h", k, o, 12'hC30);
      else n_pass++;
      step();
    end
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL inv_clear_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
  endtask

  task automatic test_start_busy();
    logic [11:0] o;
    logic [31:0] e;
    e = 32'h31323334;
    ascii_ready = 1'b1; bcd_in = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        start = 1'b1; bcd_in = 16'h5555;
      end else begin
        start = 1'b0;
      end
      o = obs();
      n_total++;
      if (o !== {4'b1100, e[31-8*k -: 8]})
        $display("FAIL busy_char%0d: got %h want %h", k, o, {4'b1100, e[31-8*k -: 8]});
      else n_pass++;
      step();
    end
    // start held through DONE (ignored) and into the following IDLE cycle
    start = 1'b1; bcd_in = 16'h5555;
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL busy_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
    bcd_in = 16'h6789;
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0000) $display("FAIL busy_start_in_done: got %b want %b", o[11:8], 4'b0000);
    else n_pass++;
    step();
    start = 1'b0;
    e = 32'h36373839;
    for (int k = 0; k < 4; k++) begin
      o = obs();
      n_total++;
      if (o !== {4'b1100, e[31-8*k -: 8]})
        $display("FAIL b2b_char%0d: got %h want %h", k, o, {4'b1100, e[31-8*k -: 8]});
      else n_pass++;
      step();
    end
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL b2b_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_midword();
    logic [11:0] o;
    ascii_ready = 1'b1; bcd_in = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    step();
    o = obs();
    n_total++;
    if (o !== 12'hC32) $display("FAIL rst_pending: got %h want %h", o, 12'hC32);
    else n_pass++;
    ascii_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ascii_ready = 1'b1;
    o = obs();
    n_total++;
    if (o !== 12'h000) $display("FAIL rst_midword: got %h want %h", o, 12'h000);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      o = obs();
      n_total++;
      if (o !== 12'h000) $display("FAIL rst_quiet%0d: got %h want %h", k, o, 12'h000);
      else n_pass++;
    end
  endtask

`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
  task automatic test_blanking();
    logic [11:0] o;
    ascii_ready = 1'b1; bcd_in = 16'h0042; start = 1'b1;
    step();
    start = 1'b0;
    o = obs();
    n_total++;
    if (o !== 12'hC34) $display("FAIL blank_c0: got %h want %h", o, 12'hC34);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o !== 12'hC32) $display("FAIL blank_c1: got %h want %h", o, 12'hC32);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL blank_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
    bcd_in = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    o = obs();
    n_total++;
    if (o !== 12'hC30) $display("FAIL blank_zero: got %h want %h", o, 12'hC30);
    else n_pass++;
    step();
    o = obs();
    n_total++;
    if (o[11:8] !== 4'b0010) $display("FAIL blank_zero_done: got %b want %b", o[11:8], 4'b0010);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
    test_blanking();
`else
    test_basic();
    test_backpressure();
    test_invalid();
    test_start_busy();
`endif
    test_reset_midword();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
